// File: rtl/de10lite_hex_pwm_driver.sv
// Two-digit 7-segment driver with 16-level PWM dimming and tear-free updates.
// Optional per-digit blinking is built only when HEX_PWM_BLINK_EN is defined.
module de10lite_hex_pwm_driver #(
    parameter int PWM_DIV       = 16,
    parameter int BLINK_PERIODS = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seg_in,
    input  logic [3:0]  brightness,
    input  logic [1:0]  blink_mask,
    output logic [7:0]  hex0,
    output logic [7:0]  hex1,
    output logic        period_tick,
    output logic        blink_phase
);

    localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PWM_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    step_q, step_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [3:0]    bright_q, bright_d;
    logic [7:0]    hex0_q, hex0_d;
    logic [7:0]    hex1_q, hex1_d;
    logic          tick_q;
    logic          boundary;
    logic          lit;
    logic [1:0]    blank;

    always_comb begin
        boundary = (presc_q == PRESC_LAST) && (step_q == 4'hF);
        presc_d  = presc_q + 1'b1;
        step_d   = step_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            step_d  = step_q + 4'd1;
        end
        shadow_d = boundary ? seg_in     : shadow_q;
        bright_d = boundary ? brightness : bright_q;
    end

`ifdef HEX_PWM_BLINK_EN
    localparam int BW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_PERIODS - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (boundary) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    // blink_mask is deliberately live, not shadowed with the segment data
    assign blank       = {2{phase_q}} & blink_mask;
    assign blink_phase = phase_q;
`else
    logic blink_mask_unused;
    assign blink_mask_unused = ^blink_mask;
    assign blank             = 2'b00;
    assign blink_phase       = 1'b0;
`endif

    always_comb begin
        lit    = (bright_q == 4'hF) || (step_q < bright_q);
        hex0_d = (!lit || blank[0]) ? 8'hFF : shadow_q[7:0];
        hex1_d = (!lit || blank[1]) ? 8'hFF : shadow_q[15:8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q  <= '0;
            step_q   <= 4'd0;
            shadow_q <= 16'hFFFF;
            bright_q <= 4'd0;
            hex0_q   <= 8'hFF;
            hex1_q   <= 8'hFF;
            tick_q   <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            step_q   <= step_d;
            shadow_q <= shadow_d;
            bright_q <= bright_d;
            hex0_q   <= hex0_d;
            hex1_q   <= hex1_d;
            tick_q   <= boundary;
        end
    end

    assign hex0        = hex0_q;
    assign hex1        = hex1_q;
    assign period_tick = tick_q;

endmodule
